chunked_add_accum: RTL and testbench

CHUNKED_ADD_ACCUM -- requirements
Module: chunked_add_accum

---
 rtl/chunked_add_accum_pkg.sv | 36 +++
 rtl/chunked_add_accum_chunk_adder.sv | 22 ++
 rtl/chunked_add_accum.sv | 125 ++++++++++++
 tb/tb_chunked_add_accum.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/chunked_add_accum_pkg.sv
// Shared types for chunked_add_accum: operation modes, FSM states,
// flag bit positions and a flag-packing helper.
package chunked_add_accum_pkg;

  typedef enum logic [1:0] {
    MODE_ADD = 2'd0,
    MODE_SUB = 2'd1,
    MODE_ACC = 2'd2,
    MODE_CLR = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // flags = {carry, overflow, zero}
  localparam int FLAG_ZERO  = 0;
  localparam int FLAG_OVF   = 1;
  localparam int FLAG_CARRY = 2;

  function automatic logic [2:0] make_flags(
    input logic c,
    input logic v,
    input logic z
  );
    logic [2:0] f;
    f = '0;
    f[FLAG_CARRY] = c;
    f[FLAG_OVF]   = v;
    f[FLAG_ZERO]  = z;
    return f;
  endfunction

endpackage

// File: rtl/chunked_add_accum_chunk_adder.sv
// chunk_adder: CHUNK-bit adder slice.
// Ports: a, b, cin -> sum, cout, msb_cin (carry into the top bit).
module chunk_adder #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             msb_cin
);

  logic [CHUNK:0] full;

  assign full = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
  assign sum  = full[CHUNK-1:0];
  assign cout = full[CHUNK];
  // sum bit = a ^ b ^ carry-in, so the carry into the MSB falls out
  assign msb_cin = full[CHUNK-1] ^ a[CHUNK-1] ^ b[CHUNK-1];

endmodule

// File: rtl/chunked_add_accum.sv
// chunked_add_accum: multi-cycle ADD/SUB/ACC/CLR unit, CHUNK bits/cycle.
// Ports: clk, rst, in_valid/in_ready, mode, a, b, out_valid/out_ready,
// result, flags {carry, ovf, zero}, acc (accumulator register).
module chunked_add_accum
  import chunked_add_accum_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [2:0]       flags,
  output logic [WIDTH-1:0] acc
);

  localparam int NCH = WIDTH / CHUNK;
  localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;

  if ((CHUNK < 1) || (WIDTH % CHUNK != 0)) begin : g_bad_param
    $error("chunked_add_accum: WIDTH must be a multiple of CHUNK");
  end

  state_t           state;
  mode_t            op_mode;
  logic [IW-1:0]    idx;
  logic             carry;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;

  logic [CHUNK-1:0] sum;
  logic             cout;
  logic             msb_cin;
  logic [WIDTH-1:0] res_n;
  logic             last;

  chunk_adder #(.CHUNK(CHUNK)) u_add (
    .a       (opa[int'(idx)*CHUNK +: CHUNK]),
    .b       (opb[int'(idx)*CHUNK +: CHUNK]),
    .cin     (carry),
    .sum     (sum),
    .cout    (cout),
    .msb_cin (msb_cin)
  );

  always_comb begin
    res_n = result;
    res_n[int'(idx)*CHUNK +: CHUNK] = sum;
  end

  assign last      = (idx == IW'(NCH - 1));
  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      op_mode <= MODE_ADD;
      idx     <= '0;
      carry   <= 1'b0;
      opa     <= '0;
      opb     <= '0;
      result  <= '0;
      flags   <= '0;
      acc     <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (in_valid) begin
            op_mode <= mode_t'(mode);
            idx     <= '0;
            state   <= ST_RUN;
            unique case (mode_t'(mode))
              MODE_ADD: begin
                opa   <= a;
                opb   <= b;
                carry <= 1'b0;
              end
              MODE_SUB: begin
                // a - b = a + ~b + 1
                opa   <= a;
                opb   <= ~b;
                carry <= 1'b1;
              end
              MODE_ACC: begin
                opa   <= acc;
                opb   <= a;
                carry <= 1'b0;
              end
              MODE_CLR: begin
                result <= '0;
                flags  <= make_flags(1'b0, 1'b0, 1'b1);
                acc    <= '0;
                carry  <= 1'b0;
                state  <= ST_DONE;
              end
            endcase
          end
        end
        ST_RUN: begin
          result <= res_n;
          carry  <= cout;
          idx    <= idx + 1'b1;
          if (last) begin
            state <= ST_DONE;
            flags <= make_flags(cout, cout ^ msb_cin, res_n == '0);
            if (op_mode == MODE_ACC) acc <= res_n;
          end
        end
        ST_DONE: begin
          if (out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_chunked_add_accum.sv
// Directed table-driven bench for chunked_add_accum (defaults 32/8),
// plus back-pressure and mid-operation reset sequences.
module tb_chunked_add_accum;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  mode;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [2:0]  flags;
  logic [31:0] acc;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  chunked_add_accum #(.WIDTH(32), .CHUNK(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags),
    .acc       (acc)
  );

  typedef struct {
    string       name;
    logic [1:0]  m;
    logic [31:0] av;
    logic [31:0] bv;
    logic [31:0] res;
    logic [2:0]  flg;
    logic [31:0] accv;
    int          lat;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Issue one request and wait for out_valid; leaves the result
  // presented (out_ready low) so the caller can check it.
  task automatic issue(input logic [1:0] m, input logic [31:0] av,
                       input logic [31:0] bv, output int lat);
    @(negedge clk);
    in_valid = 1'b1;
    mode = m;
    a = av;
    b = bv;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic release_out();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    int lat;
    logic [31:0] hr;
    logic [2:0]  hf;

    vecs[0]  = '{"add_wrap", 2'd0, 32'hFFFFFFFF, 32'h1,
                 32'h0, 3'b101, 32'h0, 4};
    vecs[1]  = '{"sub_5_7", 2'd1, 32'd5, 32'd7,
                 32'hFFFFFFFE, 3'b000, 32'h0, 4};
    vecs[2]  = '{"sub_7_5", 2'd1, 32'd7, 32'd5,
                 32'h2, 3'b100, 32'h0, 4};
    vecs[3]  = '{"add_ovf", 2'd0, 32'h7FFFFFFF, 32'h1,
                 32'h80000000, 3'b010, 32'h0, 4};
    vecs[4]  = '{"clr", 2'd3, 32'h55, 32'h66,
                 32'h0, 3'b001, 32'h0, 0};
    vecs[5]  = '{"acc_10", 2'd2, 32'd10, 32'hDEADBEEF,
                 32'd10, 3'b000, 32'd10, 4};
    vecs[6]  = '{"acc_20", 2'd2, 32'd20, 32'hFFFFFFFF,
                 32'd30, 3'b000, 32'd30, 4};
    vecs[7]  = '{"add_1_1", 2'd0, 32'd1, 32'd1,
                 32'd2, 3'b000, 32'd30, 4};
    vecs[8]  = '{"sub_ovf", 2'd1, 32'h80000000, 32'h1,
                 32'h7FFFFFFF, 3'b110, 32'd30, 4};
    vecs[9]  = '{"add_min", 2'd0, 32'h80000000, 32'h80000000,
                 32'h0, 3'b111, 32'd30, 4};
    vecs[10] = '{"sub_eq", 2'd1, 32'd5, 32'd5,
                 32'h0, 3'b101, 32'd30, 4};

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    mode = 2'd0;
    a = '0;
    b = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", result, 32'h0);
    chk("rst_flags", 32'(flags), 32'h0);
    chk("rst_acc", acc, 32'h0);

    for (int i = 0; i < 11; i++) begin
      issue(vecs[i].m, vecs[i].av, vecs[i].bv, lat);
      chk({vecs[i].name, "_lat"}, 32'(lat), 32'(vecs[i].lat));
      chk({vecs[i].name, "_res"}, result, vecs[i].res);
      chk({vecs[i].name, "_flags"}, 32'(flags), 32'(vecs[i].flg));
      chk({vecs[i].name, "_acc"}, acc, vecs[i].accv);
      release_out();
      chk({vecs[i].name, "_idle"}, 32'(in_ready), 32'd1);
    end

    // back-pressure: hold result 3 cycles with a competing request
    issue(2'd0, 32'h12345678, 32'h11111111, lat);
    chk("hold_lat", 32'(lat), 32'd4);
    hr = 32'h23456789;
    hf = 3'b000;
    @(negedge clk);
    in_valid = 1'b1;
    mode = 2'd2;
    a = 32'd999;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk("hold_res", result, hr);
      chk("hold_flags", 32'(flags), 32'(hf));
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      chk("hold_out_valid", 32'(out_valid), 32'd1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("hold_rel_valid", 32'(out_valid), 32'd0);
    chk("hold_rel_ready", 32'(in_ready), 32'd1);
    chk("hold_acc", acc, 32'd30);

    // reset in the middle of an ACC
    @(negedge clk);
    in_valid = 1'b1;
    mode = 2'd2;
    a = 32'd100;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("abort_acc", acc, 32'h0);
    chk("abort_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      chk("abort_no_valid", 32'(out_valid), 32'd0);
    end
    chk("abort_ready", 32'(in_ready), 32'd1);
    chk("abort_acc_after", acc, 32'h0);

    issue(2'd0, 32'd3, 32'd4, lat);
    chk("post_lat", 32'(lat), 32'd4);
    chk("post_res", result, 32'd7);
    chk("post_acc", acc, 32'h0);
    release_out();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
